// File: rtl/ad1xx_trace_buffer.sv
// Retirement-trace capture unit: records PC, instruction word and one shadowed
// register per retired instruction into a circular buffer drained over valid/ready.
module ad1xx_trace_buffer #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 30,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                mode,
   input  logic                trig_en,
   input  logic [ADDR_W-1:0]   trig_pc,
   input  logic [4:0]          watch_idx,
   input  logic                retire,
   input  logic [ADDR_W-1:0]   ret_pc,
   input  logic [31:0]         ret_inst,
   input  logic                ret_rd_we,
   input  logic [4:0]          ret_rd,
   input  logic [XLEN-1:0]     ret_rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W+1:0]   out_pc,
   output logic [31:0]         out_inst,
   output logic [XLEN-1:0]     out_reg,
   output logic [CNT_W-1:0]    count,
   output logic                overflow,
   output logic                triggered
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_FROZEN
   } state_t;

   state_t            state, state_nx;
   logic [PTR_W-1:0]  head, tail;
   logic [XLEN-1:0]   shadow;

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [31:0]       mem_inst [DEPTH];
   logic [XLEN-1:0]   mem_reg  [DEPTH];

   logic              shadow_hit, trig_hit, full, pop, push_try;
   logic              do_write, adv_head, adv_tail, set_ovf;
   logic [XLEN-1:0]   rec_reg;

   // The record must see a same-cycle write to the watched register.
   assign shadow_hit = retire & ret_rd_we & (ret_rd == watch_idx) & (ret_rd != 5'd0);
   assign rec_reg    = shadow_hit ? ret_rd_data : shadow;

   assign trig_hit   = retire & (ret_pc == trig_pc);
   assign full       = (count == CNT_W'(DEPTH));
   assign out_valid  = (count != '0);
   assign pop        = out_valid & out_ready;
   assign push_try   = en & (((state == S_ARMED) & trig_hit) | ((state == S_CAPTURE) & retire));
   assign triggered  = (state == S_CAPTURE) | (state == S_FROZEN);

   always_comb begin
      state_nx = state;
      do_write = 1'b0;
      adv_head = pop;
      adv_tail = 1'b0;
      set_ovf  = 1'b0;

      unique case (state)
         S_IDLE:    if (en) state_nx = trig_en ? S_ARMED : S_CAPTURE;
         S_ARMED:   if (trig_hit) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = S_CAPTURE;
         S_FROZEN:  state_nx = S_FROZEN;
         default:   state_nx = S_IDLE;
      endcase

      if (push_try) begin
         if (!full || pop) begin
            do_write = 1'b1;
            adv_tail = 1'b1;
         end else if (mode) begin
            // Wrap: overwrite the oldest slot and slide the window forward.
            do_write = 1'b1;
            adv_tail = 1'b1;
            adv_head = 1'b1;
            set_ovf  = 1'b1;
         end else begin
            set_ovf  = 1'b1;
            state_nx = S_FROZEN;
         end
      end

      if (!en) state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         shadow   <= '0;
      end else begin
         state <= state_nx;
         if (adv_head) head <= head + PTR_W'(1);
         if (adv_tail) tail <= tail + PTR_W'(1);
         if (adv_tail && !adv_head)      count <= count + CNT_W'(1);
         else if (adv_head && !adv_tail) count <= count - CNT_W'(1);
         if (set_ovf)    overflow <= 1'b1;
         if (shadow_hit) shadow   <= ret_rd_data;
      end
   end

   // NOTE: storage is deliberately not reset; the count gates what is readable,
   // so resetting the array would only add a reset fan-out to every bit.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_pc[tail]   <= ret_pc;
         mem_inst[tail] <= ret_inst;
         mem_reg[tail]  <= rec_reg;
      end
   end

   // Mask with out_valid so never-written slots cannot leak X onto the port.
   assign out_pc   = out_valid ? {mem_pc[head], 2'b00} : '0;
   assign out_inst = out_valid ? mem_inst[head] : '0;
   assign out_reg  = out_valid ? mem_reg[head]  : '0;

endmodule

// File: tb/tb_ad1xx_trace_buffer.sv
// Directed plus randomized bench for ad1xx_trace_buffer, checked every cycle
// against a queue-based model of the trace rules.
module tb_ad1xx_trace_buffer;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 30;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   localparam int P_IDLE    = 0;
   localparam int P_ARMED   = 1;
   localparam int P_CAPTURE = 2;
   localparam int P_FROZEN  = 3;

   logic              clk = 1'b0;
   logic              reset, en, mode, trig_en, retire, ret_rd_we, out_ready;
   logic [ADDR_W-1:0] trig_pc, ret_pc;
   logic [4:0]        watch_idx, ret_rd;
   logic [31:0]       ret_inst;
   logic [XLEN-1:0]   ret_rd_data;
   logic              out_valid, overflow, triggered;
   logic [ADDR_W+1:0] out_pc;
   logic [31:0]       out_inst;
   logic [XLEN-1:0]   out_reg;
   logic [CNT_W-1:0]  count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rv;
   } rec_t;

   rec_t        q[$];
   int          phase;
   bit          m_ovf;
   logic [31:0] m_shadow;

   ad1xx_trace_buffer #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .trig_en(trig_en),
      .trig_pc(trig_pc), .watch_idx(watch_idx), .retire(retire), .ret_pc(ret_pc),
      .ret_inst(ret_inst), .ret_rd_we(ret_rd_we), .ret_rd(ret_rd),
      .ret_rd_data(ret_rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_reg(out_reg), .count(count),
      .overflow(overflow), .triggered(triggered)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Applies the trace rules for the inputs currently driven, one clock's worth.
   task automatic model_step();
      logic [31:0] nsh;
      bit          popd, match, want;
      int          nphase;
      rec_t        r;
      if (reset) begin
         q.delete();
         m_shadow = '0;
         phase    = P_IDLE;
         m_ovf    = 1'b0;
         return;
      end
      nsh    = (retire && ret_rd_we && ret_rd == watch_idx && ret_rd != 0) ? ret_rd_data : m_shadow;
      popd   = (q.size() != 0) && out_ready;
      match  = retire && (ret_pc == trig_pc);
      want   = en && ((phase == P_ARMED && match) || (phase == P_CAPTURE && retire));
      nphase = phase;
      if (phase == P_IDLE && en) nphase = trig_en ? P_ARMED : P_CAPTURE;
      if (phase == P_ARMED && match) nphase = P_CAPTURE;
      if (popd) void'(q.pop_front());
      if (want) begin
         r = '{pc: {ret_pc, 2'b00}, inst: ret_inst, rv: nsh};
         if (q.size() < DEPTH) q.push_back(r);
         else if (mode) begin
            void'(q.pop_front());
            q.push_back(r);
            m_ovf = 1'b1;
         end else begin
            m_ovf  = 1'b1;
            nphase = P_FROZEN;
         end
      end
      if (!en) nphase = P_IDLE;
      phase    = nphase;
      m_shadow = nsh;
   endtask

   task automatic compare_all();
      check("count", count, q.size());
      check("out_valid", out_valid, q.size() != 0);
      check("overflow", overflow, m_ovf);
      check("triggered", triggered, (phase == P_CAPTURE) || (phase == P_FROZEN));
      check("xfree", ^{out_pc, out_inst, out_reg} === 1'bx, 1'b0);
      if (q.size() != 0) begin
         check("out_pc", out_pc, q[0].pc);
         check("out_inst", out_inst, q[0].inst);
         check("out_reg", out_reg, q[0].rv);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic ret(input logic [ADDR_W-1:0] pc, input logic [31:0] inst,
                      input logic we, input logic [4:0] rd, input logic [31:0] d);
      retire      = 1'b1;
      ret_pc      = pc;
      ret_inst    = inst;
      ret_rd_we   = we;
      ret_rd      = rd;
      ret_rd_data = d;
      cyc();
      retire = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      en        = 1'b0;
      retire    = 1'b0;
      out_ready = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 1'b0; trig_en = 1'b0; trig_pc = '0;
      watch_idx = '0; retire = 1'b0; ret_pc = '0; ret_inst = '0; ret_rd_we = 1'b0;
      ret_rd = '0; ret_rd_data = '0; out_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_count", count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_trig", triggered, 0);

      // Plain capture, in-order drain; x0 write does not touch the shadow
      en = 1'b1;
      cyc();
      ret(30'h0, 32'h00000013, 1'b1, 5'd0, 32'h0);
      ret(30'h1, 32'h00000013, 1'b1, 5'd0, 32'h0);
      ret(30'h2, 32'h00000013, 1'b1, 5'd0, 32'hdeadbeef);
      check("t1_count", count, 3);
      check("t1_pc0", out_pc, 32'h0);
      out_ready = 1'b1;
      cyc();
      check("t1_pc1", out_pc, 32'h4);
      cyc();
      check("t1_pc2", out_pc, 32'h8);
      check("t1_x0_reg", out_reg, 32'h0);
      cyc();
      check("t1_empty", out_valid, 0);
      out_ready = 1'b0;

      // Watched register shadow, same-cycle write included
      do_reset();
      watch_idx = 5'd12; en = 1'b1;
      cyc();
      ret(30'h10, 32'h00500613, 1'b1, 5'd12, 32'd5);
      ret(30'h11, 32'hffdff06f, 1'b1, 5'd0, 32'h48);
      check("t2_reg0", out_reg, 32'd5);
      out_ready = 1'b1;
      cyc();
      check("t2_reg1", out_reg, 32'd5);
      check("t2_inst1", out_inst, 32'hffdff06f);
      cyc();
      out_ready = 1'b0;

      // PC-match trigger
      do_reset();
      watch_idx = 5'd0; trig_en = 1'b1; trig_pc = 30'h3; en = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         ret(ADDR_W'(i), 32'h00000013, 1'b0, 5'd0, 32'h0);
         if (i == 2) check("t3_pre_trig", triggered, 0);
         if (i == 3) check("t3_trig", triggered, 1);
      end
      check("t3_count", count, 3);
      check("t3_pc0", out_pc, 32'hC);
      out_ready = 1'b1;
      cyc();
      check("t3_pc1", out_pc, 32'h10);
      cyc();
      check("t3_pc2", out_pc, 32'h14);
      cyc();
      out_ready = 1'b0; trig_en = 1'b0;

      // Wrap mode overwrites the oldest
      do_reset();
      mode = 1'b1; en = 1'b1;
      cyc();
      for (int i = 0; i < 20; i++) ret(ADDR_W'(i), 32'h00000013, 1'b0, 5'd0, 32'h0);
      check("t4_count", count, 16);
      check("t4_ovf", overflow, 1);
      check("t4_pc", out_pc, 32'h10);

      // Full with push and pop together in wrap mode
      do_reset();
      mode = 1'b1; en = 1'b1;
      cyc();
      for (int i = 0; i < 16; i++) ret(ADDR_W'(i), 32'h00000013, 1'b0, 5'd0, 32'h0);
      out_ready = 1'b1;
      ret(30'h20, 32'h00000013, 1'b0, 5'd0, 32'h0);
      out_ready = 1'b0;
      check("t5b_count", count, 16);
      check("t5b_ovf", overflow, 0);
      check("t5b_pc", out_pc, 32'h4);

      // Stop-when-full freezes
      do_reset();
      mode = 1'b0; en = 1'b1;
      cyc();
      for (int i = 0; i < 17; i++) ret(ADDR_W'(i), 32'h00000013, 1'b0, 5'd0, 32'h0);
      check("t5_count", count, 16);
      check("t5_ovf", overflow, 1);
      check("t5_frozen", triggered, 1);
      out_ready = 1'b1;
      ret(30'h30, 32'h00000013, 1'b0, 5'd0, 32'h0);
      out_ready = 1'b0;
      ret(30'h31, 32'h00000013, 1'b0, 5'd0, 32'h0);
      check("t5_ignored", count, 15);
      check("t5_head", out_pc, 32'h4);

      // Reset during a drain
      do_reset();
      en = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) ret(ADDR_W'(i), 32'h00000013, 1'b0, 5'd0, 32'h0);
      check("t6_pre", count, 5);
      out_ready = 1'b1; reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("t6_count", count, 0);
      check("t6_valid", out_valid, 0);
      check("t6_ovf", overflow, 0);
      check("t6_trig", triggered, 0);
      out_ready = 1'b0;

      // Randomized traffic against the model
      begin
         int drain_bias = 2;
         for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) drain_bias = $urandom_range(0, 4);
            reset       = ($urandom_range(0, 249) == 0);
            en          = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 29) == 0) trig_en = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) watch_idx = 5'($urandom_range(0, 3));
            trig_pc     = ADDR_W'($urandom_range(0, 7));
            retire      = ($urandom_range(0, 2) != 0);
            ret_pc      = ADDR_W'($urandom_range(0, 7));
            ret_inst    = $urandom;
            ret_rd_we   = $urandom_range(0, 1);
            ret_rd      = 5'($urandom_range(0, 3));
            ret_rd_data = $urandom;
            out_ready   = ($urandom_range(0, 4) < drain_bias);
            cyc();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
